// File: rtl/udp_deframer.sv
// udp_deframer: removes the 8-byte UDP header from the IPv4 payload stream.
// Non-UDP and malformed datagrams are dropped. Output is trimmed to the UDP
// length, and trailing Ethernet padding is swallowed. Ports, IPs and payload
// length are presented as per-packet sideband, held until the next header.
//
// Ports:
//   clk, sresetn                 clock, synchronous active-low reset
//   axis_i_*                     IP payload stream + per-packet IP sideband
//   axis_o_*                     UDP payload stream + per-packet UDP sideband
//   stat_drop                    one-cycle pulse per discarded datagram
//   stat_truncated               one-cycle pulse when input ends before UDP length
//
// Build option: define UDP_PORT_FILTER_EN to accept only datagrams whose
// destination port equals LISTEN_PORT.
module udp_deframer #(
  parameter logic [15:0] LISTEN_PORT = 16'd0
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic [31:0] axis_i_tdata,
  input  logic [3:0]  axis_i_tkeep,
  input  logic        axis_i_tvalid,
  output logic        axis_i_tready,
  input  logic        axis_i_tlast,
  input  logic [15:0] axis_i_length_bytes,
  input  logic [7:0]  axis_i_protocol,
  input  logic [31:0] axis_i_src_ip,
  input  logic [31:0] axis_i_dst_ip,
  output logic [31:0] axis_o_tdata,
  output logic [3:0]  axis_o_tkeep,
  output logic        axis_o_tvalid,
  input  logic        axis_o_tready,
  output logic        axis_o_tlast,
  output logic [15:0] axis_o_length_bytes,
  output logic [15:0] axis_o_src_port,
  output logic [15:0] axis_o_dst_port,
  output logic [31:0] axis_o_src_ip,
  output logic [31:0] axis_o_dst_ip,
  output logic        stat_drop,
  output logic        stat_truncated
);

  localparam int unsigned AXIS_BYTES = 4;
  localparam int unsigned LEN_W      = 16;
  localparam logic [7:0]       PROTO_UDP   = 8'd17;
  localparam logic [LEN_W-1:0] UDP_HDR_LEN = LEN_W'(8);
  localparam logic [LEN_W-1:0] MIN_ULEN    = LEN_W'(9);

  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DROP} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             drop_n, trunc_n;
  logic             hdr_load, len_load;
  logic             beat, is_last, port_reject;
  logic [3:0]       keep_mask;
  logic [15:0]      hdr_src, hdr_dst, ulen;

  // Header fields arrive in network byte order, byte 0 in the low lane.
  assign hdr_src = {axis_i_tdata[7:0], axis_i_tdata[15:8]};
  assign hdr_dst = {axis_i_tdata[23:16], axis_i_tdata[31:24]};
  assign ulen    = {axis_i_tdata[7:0], axis_i_tdata[15:8]};

`ifdef UDP_PORT_FILTER_EN
  assign port_reject = (hdr_dst != LISTEN_PORT);
`else
  logic unused_listen_port;
  assign port_reject        = 1'b0;
  assign unused_listen_port = ^LISTEN_PORT;
`endif

  // Payload passes straight through; header and drop states always accept.
  assign axis_i_tready = (state == PAYLOAD) ? axis_o_tready : 1'b1;
  assign beat          = axis_i_tvalid && axis_i_tready;
  assign is_last       = (rem <= LEN_W'(AXIS_BYTES));

  // Valid-byte mask for the final beat; rem is 1..4 whenever it is used.
  always_comb begin
    keep_mask = 4'hF;
    case (rem[1:0])
      2'd1:    keep_mask = 4'h1;
      2'd2:    keep_mask = 4'h3;
      2'd3:    keep_mask = 4'h7;
      default: keep_mask = 4'hF;
    endcase
  end

  assign axis_o_tvalid = (state == PAYLOAD) && axis_i_tvalid;
  assign axis_o_tdata  = axis_i_tdata;
  assign axis_o_tkeep  = is_last ? keep_mask : axis_i_tkeep;
  assign axis_o_tlast  = is_last || axis_i_tlast;

  // Next-state and per-beat control.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    drop_n   = 1'b0;
    trunc_n  = 1'b0;
    hdr_load = 1'b0;
    len_load = 1'b0;
    unique case (state)
      HDR0: begin
        if (beat) begin
          hdr_load = 1'b1;
          if ((axis_i_protocol != PROTO_UDP) || port_reject || axis_i_tlast) begin
            drop_n  = 1'b1;
            state_n = axis_i_tlast ? HDR0 : DROP;
          end else begin
            state_n = HDR1;
          end
        end
      end
      HDR1: begin
        if (beat) begin
          if ((ulen < MIN_ULEN) || (ulen > axis_i_length_bytes) || axis_i_tlast) begin
            drop_n  = 1'b1;
            state_n = axis_i_tlast ? HDR0 : DROP;
          end else begin
            len_load = 1'b1;
            rem_n    = ulen - UDP_HDR_LEN;
            state_n  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (beat) begin
          if (is_last) begin
            // Anything after the UDP length is padding and is swallowed silently.
            state_n = axis_i_tlast ? HDR0 : DROP;
          end else begin
            rem_n = rem - LEN_W'(AXIS_BYTES);
            if (axis_i_tlast) begin
              trunc_n = 1'b1;
              state_n = HDR0;
            end
          end
        end
      end
      DROP: begin
        if (beat && axis_i_tlast) state_n = HDR0;
      end
      default: state_n = HDR0;
    endcase
  end

  // State, remaining-length counter, sideband and stat registers.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state               <= HDR0;
      rem                 <= '0;
      axis_o_length_bytes <= '0;
      axis_o_src_port     <= '0;
      axis_o_dst_port     <= '0;
      axis_o_src_ip       <= '0;
      axis_o_dst_ip       <= '0;
      stat_drop           <= 1'b0;
      stat_truncated      <= 1'b0;
    end else begin
      state          <= state_n;
      rem            <= rem_n;
      stat_drop      <= drop_n;
      stat_truncated <= trunc_n;
      if (hdr_load) begin
        axis_o_src_port <= hdr_src;
        axis_o_dst_port <= hdr_dst;
        axis_o_src_ip   <= axis_i_src_ip;
        axis_o_dst_ip   <= axis_i_dst_ip;
      end
      if (len_load) axis_o_length_bytes <= rem_n;
    end
  end

endmodule

// File: doc/udp_deframer.md
Name: udp_deframer

Overview:
Strips the 8-byte UDP header from the payload stream produced by the IPv4 deframing stage, and sits directly downstream of it. Drops non-UDP and malformed datagrams. Trims the output to the UDP length field. Presents ports, IPs and payload length as per-packet sideband, stable for the whole output packet.

Parameters:
AXIS_BYTES, 4 (localparam, fixed), stream width in bytes; only 4 is supported.
LISTEN_PORT, 16'd0, destination port accepted; used only when UDP_PORT_FILTER_EN is defined.

Ports:
clk  in  1  clock
sresetn  in  1  synchronous reset, active low
axis_i_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  32/4/1/1/1  IP payload stream; byte 0 of the wire is tdata[7:0]
axis_i_length_bytes  in  16  IP payload length; stable from first beat to tlast
axis_i_protocol  in  8  IP protocol; stable as above
axis_i_src_ip / axis_i_dst_ip  in  32/32  stable as above
axis_o_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  32/4/1/1/1  UDP payload stream
axis_o_length_bytes  out  16  UDP length - 8
axis_o_src_port / axis_o_dst_port  out  16/16  host order
axis_o_src_ip / axis_o_dst_ip  out  32/32  registered copy of the inputs
stat_drop  out  1  one-cycle pulse per packet discarded
stat_truncated  out  1  one-cycle pulse when input tlast arrives before UDP length is reached

Behaviour:
- One clock (clk). Reset synchronous, active low (sresetn).
- Reset values: state HDR0; all sideband outputs 0; stat_* 0; axis_o_tvalid 0. Reset mid-packet discards the rest of the packet; the next beat seen is treated as word 0.
- Handshake: axis_i_tready = 1 in HDR0, HDR1 and DROP.
  - In PAYLOAD: axis_i_tready = axis_o_tready, axis_o_tvalid = axis_i_tvalid.
  - Payload has zero latency; no combinational path from tready back to tready other than this pass-through.
- Beat = axis_i_tvalid && axis_i_tready.
- HDR0 (beat):
  - src_port = {d[7:0],d[15:8]}; dst_port = {d[23:16],d[31:24]}.
  - Latch axis_i_src_ip/dst_ip.
  - If axis_i_protocol != 17: go to DROP, or HDR0 with stat_drop if tlast.
  - Else if tlast: HDR0 with stat_drop.
  - Else: HDR1.
- HDR1 (beat):
  - ulen = {d[7:0],d[15:8]}; checksum ignored.
  - Drop if ulen < 9, ulen > axis_i_length_bytes, or tlast.
  - Drop goes to DROP; if tlast, HDR0 with stat_drop.
  - Else: axis_o_length_bytes = ulen - 8; rem = ulen - 8; go to PAYLOAD.
  - ulen = 8 (empty payload) counts as a drop; no zero-length packets are emitted.
- PAYLOAD (beat):
  - is_last = (rem <= 4).
  - axis_o_tlast = is_last || axis_i_tlast.
  - axis_o_tkeep = is_last ? mask(rem) : axis_i_tkeep, where mask(1..4) = 1/3/7/F.
  - rem decrements by 4 per beat (16-bit, never underflows because of the is_last guard).
  - is_last && !axis_i_tlast: go to DROP to swallow the trailer (Ethernet padding). No stat_drop.
  - is_last && axis_i_tlast: go to HDR0.
  - axis_i_tlast && !is_last: go to HDR0 with stat_truncated pulse.
- DROP: consume beats; on tlast go to HDR0.
  - stat_drop pulses when entering DROP from HDR0/HDR1, never for trailer swallowing.
- Sideband outputs update only on HDR0/HDR1 beats. They are held until the next packet's header beats.
- stat_drop and stat_truncated are asserted in the cycle after the triggering beat.

Optional Feature:
UDP_PORT_FILTER_EN
- Defined: in HDR0, a protocol-17 packet with dst_port != LISTEN_PORT goes to DROP with stat_drop.
- Undefined: every destination port is accepted and LISTEN_PORT is unused.

Test Plan:
- Proto 17, IP len 20, UDP src 0x1234, dst 0x0050, ulen 20, 12 payload bytes -> 3 output beats, tkeep F/F/F, tlast on beat 3; ports 0x1234/0x0050; length 12.
- IP len 46, ulen 13, 5 payload bytes + 33 pad bytes -> 2 output beats, last tkeep 4'h1; padding swallowed; next packet parses correctly.
- Proto 6 (TCP), 4-beat packet -> no output beats, stat_drop pulses once, input always ready.
- ulen 8, then ulen 0x00FF > IP length 16 -> both dropped, two stat_drop pulses, no output.
- ulen 40 but input tlast after 8 payload bytes -> 2 beats, tlast with input tkeep, stat_truncated = 1.
- Random axis_o_tready backpressure on the first test -> identical data; axis_i_tready follows axis_o_tready in PAYLOAD. With UDP_PORT_FILTER_EN and LISTEN_PORT 0x0050: dst 0x0051 dropped, dst 0x0050 passed.
